// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern and BCD code constants shared by encode/decode paths
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef struct packed {
    logic [3:0] code;
    logic       err;
  } seg_decode_t;

  // True when exactly one bit is set; narrower strobe buses are zero-extended by the caller.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational segment pattern to BCD code lookup
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0]  seg_i,
  output seg_decode_t dec_o
);

  always_comb begin
    dec_o.err = 1'b0;
    case (seg_i)
      SEG_0:     dec_o.code = 4'd0;
      SEG_1:     dec_o.code = 4'd1;
      SEG_2:     dec_o.code = 4'd2;
      SEG_3:     dec_o.code = 4'd3;
      SEG_4:     dec_o.code = 4'd4;
      SEG_5:     dec_o.code = 4'd5;
      SEG_6:     dec_o.code = 4'd6;
      SEG_7:     dec_o.code = 4'd7;
      SEG_8:     dec_o.code = 4'd8;
      SEG_9:     dec_o.code = 4'd9;
      SEG_BLANK: dec_o.code = BCD_BLANK;
      default: begin
        dec_o.code = BCD_ERR;
        dec_o.err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers packed BCD frames from a multiplexed seven-segment bus
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg,
  input  logic [NDIGITS-1:0]     dig_en,
  output logic [4*NDIGITS-1:0]   bcd,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   strobe_err
);

  localparam logic [3:0] CAP_AT = 4'(STABLE_CYCLES - 1);

  logic [NDIGITS-1:0]   prev_dig_q;
  logic [6:0]           prev_seg_q;
  logic [3:0]           cnt_q, cnt_d;
  logic                 captured_q, captured_d;
  logic [4*NDIGITS-1:0] shadow_q, shadow_d;
  logic [NDIGITS-1:0]   seen_q, seen_d;
  logic [NDIGITS-1:0]   err_q, err_d;
  logic [4*NDIGITS-1:0] bcd_q, bcd_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 strobe_err_q, strobe_err_d;

  logic        onehot, multi, same, capture;
  seg_decode_t dec;

  seg7_to_bcd u_dec (
    .seg_i (seg),
    .dec_o (dec)
  );

  assign onehot = is_onehot(8'(dig_en));
  assign multi  = (|dig_en) && !onehot;
  assign same   = (dig_en == prev_dig_q) && (seg == prev_seg_q);

  always_comb begin
    cnt_d         = 4'd0;
    captured_d    = 1'b0;
    capture       = 1'b0;
    shadow_d      = shadow_q;
    seen_d        = seen_q;
    err_d         = err_q;
    bcd_d         = bcd_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = 1'b0;
    strobe_err_d  = strobe_err_q | multi;

    // A new pair restarts the count at 0, so cnt_d is the cycle index within the slot.
    if (onehot) begin
      if (same) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end
      capture    = (cnt_d == CAP_AT) && !(same && captured_q);
      captured_d = (same && captured_q) || capture;
    end

    if (capture) begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (dig_en[i]) begin
          shadow_d[4*i +: 4] = dec.code;
          seen_d[i]          = 1'b1;
          err_d[i]           = dec.err;
        end
      end
    end

    if (&seen_d) begin
      bcd_d         = shadow_d;
      frame_err_d   = |err_d;
      frame_valid_d = 1'b1;
      seen_d        = '0;
      err_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_dig_q    <= '0;
      prev_seg_q    <= '0;
      cnt_q         <= '0;
      captured_q    <= 1'b0;
      shadow_q      <= '0;
      seen_q        <= '0;
      err_q         <= '0;
      bcd_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      strobe_err_q  <= 1'b0;
    end else begin
      prev_dig_q    <= dig_en;
      prev_seg_q    <= seg;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      err_q         <= err_d;
      bcd_q         <= bcd_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      strobe_err_q  <= strobe_err_d;
    end
  end

  assign bcd         = bcd_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign strobe_err  = strobe_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg;
  logic [ND-1:0] dig_en;
  logic [4*ND-1:0] bcd;
  logic          frame_valid, frame_err, strobe_err;

  seg7_scan_decoder #(.NDIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_en      (dig_en),
    .bcd         (bcd),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .strobe_err  (strobe_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    logic        e;
  } frame_t;

  typedef struct {
    logic [27:0] segs;
    logic [15:0] exp_bcd;
    logic        exp_err;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  frame_t got_q[$];
  frame_t exp_q[$];
  logic   prev_valid = 1'b0;

  always @(negedge clk) begin
    if (frame_valid) begin
      got_q.push_back('{bcd, frame_err});
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL no_double_valid: frame_valid high %0d cycles running, required 1", 2);
      end
    end
    prev_valid = frame_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [ND-1:0] d, input logic [6:0] s);
    dig_en = d;
    seg    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input int digit, input logic [6:0] s, input int len);
    for (int k = 0; k < len; k++) cyc(ND'(1) << digit, s);
    cyc('0, 7'h00);
  endtask

  task automatic expect_one(input string name, input logic [15:0] b, input logic e);
    chk({name, "_count"}, got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk({name, "_bcd"}, got_q[0].b, b);
      chk({name, "_err"}, got_q[0].e, e);
    end
    got_q.delete();
  endtask

  task automatic expect_none(input string name);
    chk({name, "_count"}, got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    dig_en = '0;
    seg    = 7'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc('0, 7'h00);
    got_q.delete();
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    logic [6:0] pats [10];
    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    for (int i = 0; i < 10; i++) if (p == pats[i]) return {4'(i), 1'b0};
    if (p == 7'h00) return {4'hF, 1'b0};
    return {4'hE, 1'b1};
  endfunction

  vec_t tbl [6];

  initial begin
    logic [6:0] vpats [10];
    logic [3:0] m_sh [ND];
    bit         m_seen [ND];
    bit         m_err [ND];
    bit         any_multi;
    int         nexp;

    vpats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    tbl[0] = '{{7'h4F, 7'h5B, 7'h06, 7'h3F}, 16'h3210, 1'b0};
    tbl[1] = '{{7'h07, 7'h7D, 7'h6D, 7'h66}, 16'h7654, 1'b0};
    tbl[2] = '{{7'h06, 7'h3F, 7'h6F, 7'h7F}, 16'h1098, 1'b0};
    tbl[3] = '{{7'h4F, 7'h5B, 7'h49, 7'h3F}, 16'h32E0, 1'b1};
    tbl[4] = '{{7'h4F, 7'h5B, 7'h06, 7'h00}, 16'h321F, 1'b0};
    tbl[5] = '{{7'h7B, 7'h00, 7'h7F, 7'h7F}, 16'hEF88, 1'b1};

    do_reset();
    chk("reset_bcd", bcd, 0);
    chk("reset_valid", frame_valid, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_serr", strobe_err, 0);

    // Basic frame with exact completion timing on the last digit.
    for (int d = 0; d < 3; d++) slot(d, tbl[0].segs[7*d +: 7], 4);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1000, 7'h4F);
      chk($sformatf("timing_valid_k%0d", k), frame_valid, (k == SC - 1));
    end
    cyc('0, 7'h00);
    expect_one("first_frame", 16'h3210, 1'b0);

    for (int i = 1; i < 6; i++) begin
      for (int d = 0; d < ND; d++) slot(d, tbl[i].segs[7*d +: 7], 4);
      expect_one($sformatf("tbl%0d", i), tbl[i].exp_bcd, tbl[i].exp_err);
    end

    // Short slot on digit 2 leaves the frame open until a proper digit-2 slot.
    slot(0, 7'h06, 4);
    slot(1, 7'h5B, 4);
    slot(2, 7'h4F, SC - 1);
    slot(3, 7'h66, 4);
    expect_none("short_slot");
    slot(2, 7'h6F, 4);
    expect_one("short_rescan", 16'h4921, 1'b0);

    // Multi-hot strobe mid-frame.
    slot(0, 7'h7F, 4);
    slot(1, 7'h07, 4);
    for (int k = 0; k < 5; k++) cyc(4'b0110, 7'h5B);
    chk("multi_serr", strobe_err, 1);
    cyc('0, 7'h00);
    expect_none("multi_nocap");
    slot(2, 7'h7D, 4);
    slot(3, 7'h6D, 4);
    expect_one("multi_after", 16'h5678, 1'b0);
    chk("multi_sticky", strobe_err, 1);

    // Out-of-order scan with a re-capture of digit 1.
    slot(3, 7'h07, 4);
    slot(1, 7'h06, 4);
    slot(1, 7'h66, 4);
    slot(0, 7'h7F, 4);
    expect_none("reorder_partial");
    slot(2, 7'h6D, 4);
    expect_one("reorder", 16'h7548, 1'b0);

    // Reset after three captures discards the partial frame.
    slot(0, 7'h3F, 4);
    slot(1, 7'h06, 4);
    slot(2, 7'h5B, 4);
    rst_n = 1'b0;
    #2;
    chk("midrst_bcd", bcd, 0);
    chk("midrst_serr", strobe_err, 0);
    chk("midrst_valid", frame_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc('0, 7'h00);
    slot(3, 7'h4F, 4);
    cyc('0, 7'h00);
    expect_none("midrst_lastonly");
    chk("midrst_bcd_after", bcd, 0);
    chk("midrst_ferr_after", frame_err, 0);

    // Randomized slots against a slot-level model.
    do_reset();
    got_q.delete();
    exp_q.delete();
    for (int d = 0; d < ND; d++) begin
      m_seen[d] = 0;
      m_err[d]  = 0;
      m_sh[d]   = 0;
    end
    any_multi = 0;
    for (int n = 0; n < 300; n++) begin
      int len;
      len = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) begin
        int a, b;
        a = $urandom_range(0, ND - 1);
        b = (a + $urandom_range(1, ND - 1)) % ND;
        for (int k = 0; k < len; k++) cyc((ND'(1) << a) | (ND'(1) << b), 7'($urandom_range(0, 127)));
        cyc('0, 7'h00);
        any_multi = 1;
      end else begin
        int dg;
        logic [6:0] p;
        logic [4:0] r;
        bit all;
        dg = $urandom_range(0, ND - 1);
        p  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : vpats[$urandom_range(0, 9)];
        slot(dg, p, len);
        if (len >= SC) begin
          r = ref_decode(p);
          m_sh[dg]   = r[4:1];
          m_err[dg]  = r[0];
          m_seen[dg] = 1;
          all = 1;
          for (int d = 0; d < ND; d++) all &= m_seen[d];
          if (all) begin
            frame_t f;
            f.b = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            f.e = m_err[0] | m_err[1] | m_err[2] | m_err[3];
            exp_q.push_back(f);
            for (int d = 0; d < ND; d++) begin
              m_seen[d] = 0;
              m_err[d]  = 0;
            end
          end
        end
      end
    end
    cyc('0, 7'h00);
    chk("rand_frame_count", got_q.size(), exp_q.size());
    nexp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nexp; i++) begin
      chk($sformatf("rand%0d_bcd", i), got_q[i].b, exp_q[i].b);
      chk($sformatf("rand%0d_err", i), got_q[i].e, exp_q[i].e);
    end
    chk("rand_serr", strobe_err, any_multi);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
